// File: rtl/display_mux_7seg.sv
// Multiplexed common-anode seven-segment driver with dead time,
// blanking, blinking, decimal points and leading-zero suppression.
module display_mux_7seg #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 27000,
  parameter int DEAD_CYCLES = 270,
  parameter int BLINK_DIV   = 13500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic                  load_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic [N_DIGITS-1:0]   blink_i,
  input  logic                  lz_en_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         bcnt;
  logic                  blink_ph;
  logic [4*N_DIGITS-1:0] sh_data;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blank;
  logic [N_DIGITS-1:0]   sh_blink;

  logic [3:0]            nib;
  logic [N_DIGITS-1:0]   lz_dark;
  logic [N_DIGITS-1:0]   onehot;
  logic                  run;
  logic                  in_dead;
  logic                  dark;
  logic [6:0]            seg_n;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Suppression runs from the top digit down and stops at the first nonzero
  always_comb begin
    run     = 1'b1;
    lz_dark = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run        = run & (sh_data[4*k +: 4] == 4'h0);
      lz_dark[k] = lz_en_i & run & (k != 0);
    end
  end

  always_comb begin
    nib         = sh_data[4*int'(idx) +: 4];
    in_dead     = int'(cnt) < DEAD_CYCLES;
    dark        = in_dead | sh_blank[idx] | lz_dark[idx]
                | (sh_blink[idx] & blink_ph);
    onehot      = '0;
    onehot[idx] = 1'b1;
    seg_n       = hex7(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      bcnt     <= '0;
      blink_ph <= 1'b0;
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '1;
      sh_blink <= '0;
      seg_o    <= 7'h7F;
      dp_o     <= 1'b1;
      an_o     <= '1;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (bcnt == BLK_MAX) begin
        bcnt     <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
      if (load_i) begin
        sh_data  <= data_i;
        sh_dp    <= dp_i;
        sh_blank <= blank_i;
        sh_blink <= blink_i;
      end
      if (dark) begin
        seg_o <= 7'h7F;
        dp_o  <= 1'b1;
        an_o  <= '1;
      end else begin
        seg_o <= seg_n;
        dp_o  <= ~sh_dp[idx];
        an_o  <= ~onehot;
      end
    end
  end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed bench for display_mux_7seg with short refresh/blink periods.
// Pins are packed as {an_o, seg_o, dp_o} for each comparison.
module tb_display_mux_7seg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic [3:0]  blink_i = '0;
  logic        lz_en_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] DARK = 12'hFFF;

  display_mux_7seg #(
    .N_DIGITS(4),
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2),
    .BLINK_DIV(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .load_i(load_i),
    .dp_i(dp_i),
    .blank_i(blank_i),
    .blink_i(blink_i),
    .lz_en_i(lz_en_i),
    .seg_o(seg_o),
    .dp_o(dp_o),
    .an_o(an_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] got,
                     input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pins();
    return {an_o, seg_o, dp_o};
  endfunction

  // Two reset edges, then arm a one-cycle load for the next edge
  task automatic reset_load(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] bl, input logic [3:0] bk);
    rst = 1'b1;
    step();
    chk("rst_a", pins(), DARK);
    step();
    chk("rst_b", pins(), DARK);
    rst     = 1'b0;
    load_i  = 1'b1;
    data_i  = d;
    dp_i    = dp;
    blank_i = bl;
    blink_i = bk;
  endtask

  // Sample j follows the j-th edge after reset: it shows slot position
  // (j-1)%8 of digit ((j-1)/8)%4 in blink phase ((j-1)/64)%2.
  task automatic check_scan(input string tag, input logic [27:0] segx,
                            input logic [3:0] dpx, input logic [3:0] lit0,
                            input logic [3:0] lit1, input int n);
    int pos, d, ph;
    logic [3:0]  an_x;
    logic [11:0] exp;
    for (int j = 1; j <= n; j++) begin
      step();
      load_i = 1'b0;
      pos = (j - 1) % 8;
      d   = ((j - 1) / 8) % 4;
      ph  = ((j - 1) / 64) % 2;
      an_x = 4'hF;
      an_x[d] = 1'b0;
      if (pos < 2 || !(ph == 1 ? lit1[d] : lit0[d]))
        exp = DARK;
      else
        exp = {an_x, segx[d*7 +: 7], ~dpx[d]};
      chk(tag, pins(), exp);
    end
  endtask

  initial begin
    // reset held, no load: blank shadow keeps everything dark
    rst = 1'b1;
    repeat (3) step();
    chk("reset", pins(), DARK);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("noload", pins(), DARK);
    end

    // 1234: digit0..3 = 4,3,2,1
    reset_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
    check_scan("hex1234", {7'h79, 7'h24, 7'h30, 7'h19},
               4'b0000, 4'b1111, 4'b1111, 40);
    chk("hex1234_wrap_d0", pins(), {4'b1110, 7'h19, 1'b1});

    // ABCF with dp on digit 2
    reset_load(16'hABCF, 4'b0100, 4'b0000, 4'b0000);
    check_scan("dp_abcf", {7'h08, 7'h03, 7'h46, 7'h0E},
               4'b0100, 4'b1111, 4'b1111, 32);

    // leading-zero suppression on and off
    lz_en_i = 1'b1;
    reset_load(16'h0007, 4'b0000, 4'b0000, 4'b0000);
    check_scan("lz_on", {7'h40, 7'h40, 7'h40, 7'h78},
               4'b0000, 4'b0001, 4'b0001, 32);
    lz_en_i = 1'b0;
    reset_load(16'h0007, 4'b0000, 4'b0000, 4'b0000);
    check_scan("lz_off", {7'h40, 7'h40, 7'h40, 7'h78},
               4'b0000, 4'b1111, 4'b1111, 32);

    // blink digit 0 across two blink phases
    reset_load(16'h8888, 4'b0000, 4'b0000, 4'b0001);
    check_scan("blink", {7'h00, 7'h00, 7'h00, 7'h00},
               4'b0000, 4'b1111, 4'b1110, 136);

    // forced blanking of digits 1 and 3
    reset_load(16'h5E6D, 4'b1111, 4'b1010, 4'b0000);
    check_scan("blank", {7'h12, 7'h06, 7'h02, 7'h21},
               4'b1111, 4'b0101, 4'b0101, 32);

    // reset while digit 2 is lit, then restart from digit 0
    reset_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
    check_scan("pre_rst", {7'h79, 7'h24, 7'h30, 7'h19},
               4'b0000, 4'b1111, 4'b1111, 20);
    chk("mid_d2_lit", pins(), {4'b1011, 7'h24, 1'b1});
    rst = 1'b1;
    step();
    chk("mid_rst", pins(), DARK);
    reset_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
    check_scan("post_rst", {7'h79, 7'h24, 7'h30, 7'h19},
               4'b0000, 4'b1111, 4'b1111, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
